// File: rtl/button_debouncer.sv
// Purpose : debounce N_BTN push-buttons and emit one-cycle press/release events.
// Latency : 2-flop sync + STABLE_SAMPLES strobes; event registered one cycle after the completing strobe.
// Backpr. : none; outputs are free-running registers, events are never held or queued.
//
// Ports:
//   clk          system clock (only clock in the block)
//   rst          asynchronous, active-high reset
//   clk_debounce slow square wave, sampled as data; each rising edge is one sample instant
//   btn_raw      asynchronous raw button inputs, active-high
//   btn_level    debounced registered level per button
//   btn_press    one-cycle pulse on a debounced 0->1 transition
//   btn_release  one-cycle pulse on a debounced 1->0 transition
module button_debouncer #(
    parameter int N_BTN          = 5,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_debounce,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int CW = $clog2(STABLE_SAMPLES + 1);

    // Bit 1 of the state is the debounced level.
    localparam logic [1:0] ST_LOW       = 2'b00;
    localparam logic [1:0] ST_RISE_PEND = 2'b01;
    localparam logic [1:0] ST_HIGH      = 2'b10;
    localparam logic [1:0] ST_FALL_PEND = 2'b11;

    // cnt+1 == STABLE_SAMPLES expressed without widening the counter.
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Button and strobe paths use the same synchronizer depth so a sample
    // taken on a strobe is the raw value captured alongside that edge.
    logic [N_BTN-1:0] raw_s1_q;
    logic [N_BTN-1:0] raw_s2_q;
    logic             db_s1_q;
    logic             db_s2_q;
    logic             prev_db_q;
    logic             strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_s1_q  <= '0;
            raw_s2_q  <= '0;
            db_s1_q   <= 1'b0;
            db_s2_q   <= 1'b0;
            prev_db_q <= 1'b0;
        end else begin
            raw_s1_q  <= btn_raw;
            raw_s2_q  <= raw_s1_q;
            db_s1_q   <= clk_debounce;
            db_s2_q   <= db_s1_q;
            prev_db_q <= db_s2_q;
        end
    end

    assign strobe = db_s2_q & ~prev_db_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [1:0]    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          sample;

        assign sample = raw_s2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            if (strobe) begin
                case (state_q)
                    ST_LOW: begin
                        if (sample) begin
                            if (STABLE_SAMPLES == 1) begin
                                state_d = ST_HIGH;
                                press_d = 1'b1;
                            end else begin
                                state_d = ST_RISE_PEND;
                                cnt_d   = CNT_ONE;
                            end
                        end
                    end
                    ST_RISE_PEND: begin
                        if (sample) begin
                            if (cnt_q == CNT_LAST) begin
                                state_d = ST_HIGH;
                                cnt_d   = '0;
                                press_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else begin
                            // Bounce: abandon the pending rise silently.
                            state_d = ST_LOW;
                            cnt_d   = '0;
                        end
                    end
                    ST_HIGH: begin
                        if (!sample) begin
                            if (STABLE_SAMPLES == 1) begin
                                state_d = ST_LOW;
                                rel_d   = 1'b1;
                            end else begin
                                state_d = ST_FALL_PEND;
                                cnt_d   = CNT_ONE;
                            end
                        end
                    end
                    ST_FALL_PEND: begin
                        if (!sample) begin
                            if (cnt_q == CNT_LAST) begin
                                state_d = ST_LOW;
                                cnt_d   = '0;
                                rel_d   = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else begin
                            state_d = ST_HIGH;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                // Registered from the next state so the level moves together
                // with the event pulse.
                level_q <= state_d[1];
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
    end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    localparam int N = 5;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         db  = 1'b0;
    logic [N-1:0] raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    int checks = 0;
    int errors = 0;

    button_debouncer #(.N_BTN(N), .STABLE_SAMPLES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_debounce (db),
        .btn_raw      (raw),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_release  (btn_release)
    );

    always #5 clk = ~clk;

    // Reference model: each button remembers its debounced level and how many
    // consecutive sample instants disagreed with it. Inputs reach the decision
    // two clock edges after capture; a sample instant is a 0->1 step of the
    // delayed clk_debounce.
    logic [N-1:0] m_level, m_press, m_rel;
    int           m_cnt [N];
    logic [N-1:0] h_raw1, h_raw2;
    logic         h_db1, h_db2, h_db3;
    int           m_strobes = 0;

    logic         db_run = 1'b1;
    int           ph = 0;
    int           pcount [N];
    int           rcount [N];

    task automatic model_reset();
        m_level = '0; m_press = '0; m_rel = '0;
        h_raw1 = '0; h_raw2 = '0;
        h_db1 = 1'b0; h_db2 = 1'b0; h_db3 = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic clear_acc();
        for (int i = 0; i < N; i++) begin
            pcount[i] = 0;
            rcount[i] = 0;
        end
    endtask

    task automatic check_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_press = '0;
            m_rel   = '0;
            if (h_db2 && !h_db3) begin
                m_strobes++;
                for (int i = 0; i < N; i++) begin
                    if (h_raw2[i] != m_level[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == S) begin
                            m_level[i] = ~m_level[i];
                            m_cnt[i]   = 0;
                            if (m_level[i]) m_press[i] = 1'b1;
                            else            m_rel[i]   = 1'b1;
                        end
                    end else begin
                        m_cnt[i] = 0;
                    end
                end
            end
            h_raw2 = h_raw1; h_raw1 = raw;
            h_db3 = h_db2; h_db2 = h_db1; h_db1 = db;
        end
        #1;
        check_vec("level", btn_level, m_level);
        check_vec("press", btn_press, m_press);
        check_vec("release", btn_release, m_rel);
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   pcount[i]++;
            if (btn_release[i]) rcount[i]++;
        end
        if (db_run) begin
            ph++;
            if (ph == 5) begin
                ph = 0;
                db = ~db;
            end
        end
    endtask

    task automatic wait_strobes(input int n);
        int target;
        int budget;
        target = m_strobes + n;
        budget = n * 12 + 30;
        while (m_strobes < target && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        assert (m_strobes >= target) else begin
            errors++;
            $error("FAIL strobe_timeout observed %0d expected %0d", m_strobes, target);
        end
    endtask

    task automatic reset_pulse(input int cycles);
        rst = 1'b1;
        #1;
        model_reset();
        check_vec("rst_level", btn_level, 5'b00000);
        check_vec("rst_press", btn_press, 5'b00000);
        check_vec("rst_release", btn_release, 5'b00000);
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] saved;
        int           sum;
        model_reset();
        clear_acc();

        // Reset with all buttons held, then four strobes to press them all.
        raw = 5'b11111;
        reset_pulse(3);
        clear_acc();
        wait_strobes(4);
        check_vec("all_level", btn_level, 5'b11111);
        for (int i = 0; i < N; i++) check_int("all_press_once", pcount[i], 1);

        raw = '0;
        wait_strobes(5);
        check_vec("all_released", btn_level, 5'b00000);

        // Clean press on bit 0.
        clear_acc();
        raw[0] = 1'b1;
        wait_strobes(5);
        check_int("clean_press_cnt", pcount[0], 1);
        sum = 0;
        for (int i = 0; i < N; i++) sum += rcount[i];
        check_int("clean_no_release", sum, 0);
        check_vec("clean_level", btn_level, 5'b00001);

        // Bounce on bit 2: three highs, one low, then four highs.
        clear_acc();
        raw[2] = 1'b1;
        wait_strobes(3);
        raw[2] = 1'b0;
        wait_strobes(1);
        check_int("bounce_no_press", pcount[2], 0);
        raw[2] = 1'b1;
        wait_strobes(3);
        check_int("bounce_3_of_4", pcount[2], 0);
        wait_strobes(1);
        check_int("bounce_press", pcount[2], 1);
        check_vec("bounce_level", btn_level, 5'b00101);

        // Simultaneous release on bits 1 and 3.
        raw = raw | 5'b01010;
        wait_strobes(5);
        check_vec("pair_high", btn_level, 5'b01111);
        clear_acc();
        raw = raw & 5'b10101;
        wait_strobes(5);
        check_int("rel1", rcount[1], 1);
        check_int("rel3", rcount[3], 1);
        check_int("rel0", rcount[0], 0);
        check_int("rel2", rcount[2], 0);
        check_vec("pair_low", btn_level, 5'b00101);

        // Reset while bit 4 is three samples into a pending rise.
        raw[4] = 1'b1;
        wait_strobes(3);
        reset_pulse(1);
        clear_acc();
        wait_strobes(3);
        check_int("midrst_no_press", pcount[4], 0);
        wait_strobes(1);
        check_int("midrst_fresh_press", pcount[4], 1);
        check_vec("midrst_level", btn_level, 5'b10101);

        // Stalled sampler: random button activity must not move anything.
        db_run = 1'b0;
        db = 1'b0;
        repeat (10) tick();
        saved = m_level;
        clear_acc();
        repeat (1000) begin
            raw = N'($urandom);
            tick();
        end
        sum = 0;
        for (int i = 0; i < N; i++) sum += pcount[i] + rcount[i];
        check_int("stall_no_pulse", sum, 0);
        check_vec("stall_level", btn_level, saved);

        // Random slow activity with bounces, then let everything settle.
        db_run = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) raw[$urandom_range(0, N - 1)] ^= 1'b1;
            tick();
        end
        wait_strobes(6);
        check_vec("settled_level", btn_level, raw);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces the board push-buttons and turns each clean press/release into a single `clk`-cycle event for the game controller. It runs on the 100 MHz system clock and takes the slow `clk_debounce` square wave from the clock generator as a data input, not as a clock. Every rising edge of `clk_debounce` (one per 2 ms at the nominal 500 Hz) is one sample instant. A button's debounced level changes only after `STABLE_SAMPLES` consecutive samples disagree with the current level.

## Interface
Parameters:
- `N_BTN`, 5: number of buttons handled (U, D, L, R, C on the board).
- `STABLE_SAMPLES`, 4: consecutive disagreeing samples required to flip a level; legal range 1..15.

Ports:
- `clk`  in  1  100 MHz system clock; only clock in the block.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_debounce`  in  1  slow square wave from the clock generator; sampled, never used as a clock.
- `btn_raw`  in  N_BTN  asynchronous raw button inputs, active-high.
- `btn_level`  out  N_BTN  debounced, registered button level.
- `btn_press`  out  N_BTN  one-cycle pulse on a debounced 0→1 transition.
- `btn_release`  out  N_BTN  one-cycle pulse on a debounced 1→0 transition.

Reset is asynchronous and active-high; there is one clock, `clk`.

## Operation
- **Synchronizers:** `btn_raw` and `clk_debounce` each pass through a two-flop synchronizer of identical depth, so their paths are aligned.
- **Strobe:** `prev_db` is a register of the synchronized `clk_debounce`. `strobe` is `sync_db & ~prev_db`, combinational and high for exactly one cycle per rising edge.
- **Per-button state machine:** each button has its own FSM with states LOW, RISE_PEND, HIGH and FALL_PEND, plus a counter of width clog2(STABLE_SAMPLES+1).
- **LOW:**
  - On a strobe with sample=1: `cnt <= 1` and go to RISE_PEND.
  - If STABLE_SAMPLES=1, go directly to HIGH and assert `btn_press`.
- **RISE_PEND, strobe with sample=1:**
  - If `cnt+1 == STABLE_SAMPLES`: go to HIGH, `cnt <= 0`, register `btn_press=1`.
  - Otherwise: `cnt++`.
- **RISE_PEND, strobe with sample=0:** `cnt <= 0` and return to LOW. This is a bounce and produces no pulse.
- **HIGH and FALL_PEND:** mirror LOW and RISE_PEND with the sample polarity inverted. Completion asserts `btn_release`.
- **No strobe:** FSM and counter hold. Sample changes between strobes are ignored.
- **`btn_level`:** 1 in HIGH and FALL_PEND, 0 in LOW and RISE_PEND. It is registered, so it changes in the same cycle the pulse appears.
- **Pulse rules:** `btn_press` and `btn_release` are cleared on every cycle that does not set them. The same bit never has both asserted in one cycle.
- **Independence:** buttons are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.

## Timing
- **Reset values:** all synchronizer flops, `prev_db`, counters, `btn_level`, `btn_press` and `btn_release` are 0, and every FSM is in LOW.
- **Strobe after reset:** if `clk_debounce` is already high when reset releases, a strobe fires once the synchronizer fills, 2 cycles after the first clock edge.
- **Sample latency:** a `btn_raw` change is visible to the FSM 2 `clk` cycles after it is captured.
- **Press latency:** the press pulse appears in the cycle after the STABLE_SAMPLES-th agreeing strobe. Nominal worst case is STABLE_SAMPLES×2 ms + 2 ms + 3 cycles.
- **Stopped `clk_debounce`:** if it is held constant there are no strobes, and all outputs hold indefinitely (pulses stay 0).
- **Reset mid-operation:** asserting `rst` in RISE_PEND or FALL_PEND aborts the pending transition immediately (asynchronous). No pulse is emitted, even if reset lands on the completing strobe.
- **Counter range:** the counter never exceeds STABLE_SAMPLES−1 and never wraps.

## Test plan
Bench settings: `clk_debounce` toggles every 5 `clk` cycles (strobe every 10), N_BTN=5, STABLE_SAMPLES=4.

- **Reset:** assert `rst` with `btn_raw=5'b11111` → all outputs 0 during reset. After release, `btn_press=5'b11111` for one cycle on the cycle after the 4th strobe, then `btn_level=5'b11111`.
- **Clean press:** `btn_raw[0]` 0→1 and held → exactly one `btn_press[0]` pulse, 1 cycle after the 4th strobe following synchronization. `btn_level[0]=1` from that cycle on; `btn_release` stays 0.
- **Bounce:** `btn_raw[2]` high across 3 strobes, low at the 4th, then high across 4 strobes → no pulse after the first burst; one `btn_press[2]` after the 4th strobe of the second burst.
- **Release and simultaneous buttons:** from HIGH on bits 1 and 3, drop both together → `btn_release=5'b01010` in a single cycle, then `btn_level[1]=btn_level[3]=0`. Bits 0, 2 and 4 are unaffected.
- **Reset mid-pending:** `btn_raw[4]=1` across 3 strobes, then pulse `rst` for 1 cycle → no `btn_press[4]` on the following strobe. A fresh 4 agreeing strobes are needed before the press.
- **Stalled sampler:** hold `clk_debounce=0` and toggle `btn_raw` arbitrarily for 1000 cycles → `btn_level` unchanged and no pulses.
